spi_sclk_gen: RTL and testbench

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

---
 rtl/spi_sclk_gen.sv | 155 +++++++++++++++
 tb/tb_spi_sclk_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sclk_gen
//  Purpose  : SPI serial-clock generator. Takes a start request, latches the
//             divider, pulse count and clock mode, then produces N spi_clk
//             pulses with sample/shift strobes on the appropriate edges.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         system clock, rising edge
//    rst         asynchronous active-low reset
//    clk_divide  spi_clk half-period in clk cycles (0 behaves as 1)
//    n_pulses    spi_clk pulses per transfer (clamped to SPI_MAXLEN)
//    cpol        spi_clk idle level
//    cpha        0: sample leading / shift trailing, 1: the reverse
//    start       level request, accepted only when idle
//    abort       cancels an active transfer
//    spi_clk     generated serial clock (registered)
//    sample      strobe in the cycle spi_clk shows a sampling edge
//    shift       strobe in the cycle spi_clk shows a shifting edge
//    busy        transfer in progress
//    done        one-cycle pulse at normal completion
// ============================================================================
module spi_sclk_gen #(
    parameter int SPI_MAXLEN = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_WIDTH-1:0]         clk_divide,
    input  logic [$clog2(SPI_MAXLEN):0]  n_pulses,
    input  logic                         cpol,
    input  logic                         cpha,
    input  logic                         start,
    input  logic                         abort,
    output logic                         spi_clk,
    output logic                         sample,
    output logic                         shift,
    output logic                         busy,
    output logic                         done
);

    localparam int c_nw = $clog2(SPI_MAXLEN) + 1;  // pulse-count width
    localparam int c_ew = c_nw + 1;                // edge-count width, holds 2*SPI_MAXLEN

    localparam logic [c_nw-1:0]      c_maxlen   = c_nw'(SPI_MAXLEN);
    localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);
    localparam logic [c_ew-1:0]      c_edge_one = c_ew'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [c_ew-1:0]       r_edges;
    logic [c_nw-1:0]       r_npulse;
    logic                  r_cpol;
    logic                  r_cpha;

    logic [c_nw-1:0]       w_n_clamped;
    logic [DIV_WIDTH-1:0]  w_div_eff;
    logic                  w_tc;
    logic [c_ew-1:0]       w_next_edge;
    logic [c_ew-1:0]       w_last_edge;

    assign w_n_clamped = (n_pulses > c_maxlen) ? c_maxlen : n_pulses;
    assign w_div_eff   = (clk_divide == '0) ? c_div_one : clk_divide;
    assign w_tc        = (r_cnt == (r_div - c_div_one));
    assign w_next_edge = r_edges + c_edge_one;
    assign w_last_edge = {r_npulse, 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_div    <= c_div_one;
            r_cnt    <= '0;
            r_edges  <= '0;
            r_npulse <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            spi_clk  <= 1'b0;
            sample   <= 1'b0;
            shift    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sample <= 1'b0;
            shift  <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Idle level tracks the live cpol input with one cycle of lag.
                    spi_clk <= cpol;
                    if (start && !abort) begin
                        if (w_n_clamped == '0) begin
                            // Zero-length transfer completes immediately.
                            done <= 1'b1;
                        end else begin
                            r_state  <= S_SETUP;
                            busy     <= 1'b1;
                            r_div    <= w_div_eff;
                            r_npulse <= w_n_clamped;
                            r_cpol   <= cpol;
                            r_cpha   <= cpha;
                            r_cnt    <= '0;
                            r_edges  <= '0;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        spi_clk <= r_cpol;
                    end else begin
                        r_cnt <= w_tc ? '0 : (r_cnt + c_div_one);
                        if (w_tc) begin
                            case (r_state)
                                S_SETUP, S_RUN: begin
                                    spi_clk <= ~spi_clk;
                                    r_edges <= w_next_edge;
                                    // Odd edge count = leading edge; cpha swaps roles.
                                    if (w_next_edge[0] ^ r_cpha) begin
                                        sample <= 1'b1;
                                    end else begin
                                        shift <= 1'b1;
                                    end
                                    // Final toggle starts the closing half-period.
                                    r_state <= (w_next_edge == w_last_edge) ? S_HOLD : S_RUN;
                                end
                                S_HOLD: begin
                                    r_state <= S_IDLE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                    spi_clk <= r_cpol;
                                end
                                default: begin
                                    r_state <= S_IDLE;
                                    busy    <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_sclk_gen
//  Purpose  : Self-checking bench for spi_sclk_gen. A timing model derived
//             from the transfer start cycle predicts every output each cycle;
//             directed scenarios pin event timing to literal cycle lists.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_sclk_gen;

    localparam int MAXLEN = 16;
    localparam int DIVW   = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [DIVW-1:0]           clk_divide = '0;
    logic [$clog2(MAXLEN):0]   n_pulses = '0;
    logic                      cpol = 1'b0;
    logic                      cpha = 1'b0;
    logic                      start = 1'b0;
    logic                      abort = 1'b0;
    logic                      spi_clk, sample, shift, busy, done;

    spi_sclk_gen #(.SPI_MAXLEN(MAXLEN), .DIV_WIDTH(DIVW)) dut (
        .clk(clk), .rst(rst), .clk_divide(clk_divide), .n_pulses(n_pulses),
        .cpol(cpol), .cpha(cpha), .start(start), .abort(abort),
        .spi_clk(spi_clk), .sample(sample), .shift(shift), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t_ref    = 0;

    // Model of the current transfer: first busy cycle and done cycle.
    bit m_active = 0;
    int m_t0, m_end, m_d, m_n;
    bit m_cpol, m_cpha;
    bit e_spi, e_sample, e_shift, e_busy, e_done;

    // Event logs relative to t_ref.
    int q_tog[$], q_smp[$], q_shf[$], q_done[$], q_busy[$];
    logic prev_spi = 1'b0;

    task automatic chk_bit(string nm, logic got, bit exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_int(string nm, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic string fmt(input int q[$]);
        string s;
        s = "{";
        foreach (q[i]) if (i < 16) s = {s, $sformatf(" %0d", q[i])};
        if (q.size() > 16) s = {s, " ..."};
        return {s, " }"};
    endfunction

    task automatic chk_list(string nm, input int got[$], input int exp[$]);
        bit ok;
        n_checks++;
        ok = (got.size() == exp.size());
        if (ok) foreach (exp[i]) if (got[i] != exp[i]) ok = 0;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s expected %s", nm, fmt(got), fmt(exp));
        end
    endtask

    // Outputs within a transfer follow from the offset into it.
    task automatic xfer_outputs();
        int o, q, r, k;
        o = cyc - m_t0;
        q = o / m_d;
        r = o % m_d;
        k = (q > 2 * m_n) ? 2 * m_n : q;
        e_busy = (cyc < m_end);
        e_done = (cyc == m_end);
        e_spi  = m_cpol ^ k[0];
        if (r == 0 && q >= 1 && q <= 2 * m_n) begin
            if ((q % 2 == 1) != m_cpha) e_sample = 1;
            else                        e_shift  = 1;
        end
    endtask

    task automatic model_step();
        int n;
        e_sample = 0; e_shift = 0; e_busy = 0; e_done = 0;
        if (!rst) begin
            m_active = 0;
            e_spi    = 0;
        end else if (m_active && (cyc - 1) < m_end) begin
            if (abort) begin
                m_active = 0;
                e_spi    = m_cpol;
            end else begin
                xfer_outputs();
            end
        end else begin
            m_active = 0;
            e_spi    = cpol;
            if (start && !abort) begin
                n = (int'(n_pulses) > MAXLEN) ? MAXLEN : int'(n_pulses);
                if (n == 0) begin
                    e_done = 1;
                end else begin
                    m_active = 1;
                    m_t0     = cyc;
                    m_d      = (clk_divide == 0) ? 1 : int'(clk_divide);
                    m_n      = n;
                    m_cpol   = cpol;
                    m_cpha   = cpha;
                    m_end    = cyc + (2 * n + 1) * m_d;
                    xfer_outputs();
                end
            end
        end
    endtask

    // Compare process: model advances on each rising edge, DUT is sampled 1ns later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            chk_bit("spi_clk", spi_clk, e_spi);
            chk_bit("sample",  sample,  e_sample);
            chk_bit("shift",   shift,   e_shift);
            chk_bit("busy",    busy,    e_busy);
            chk_bit("done",    done,    e_done);
            if (rst) begin
                if (spi_clk !== prev_spi) q_tog.push_back(cyc - t_ref);
                if (sample) q_smp.push_back(cyc - t_ref);
                if (shift)  q_shf.push_back(cyc - t_ref);
                if (done)   q_done.push_back(cyc - t_ref);
                if (busy)   q_busy.push_back(cyc - t_ref);
            end
            prev_spi = spi_clk;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        q_tog.delete(); q_smp.delete(); q_shf.delete(); q_done.delete(); q_busy.delete();
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; raises start for exactly one cycle.
    task automatic start_xfer(int div, int n, bit pol, bit pha);
        clk_divide = DIVW'(div);
        n_pulses   = 5'(n);
        cpol       = pol;
        cpha       = pha;
        clear_logs();
        t_ref = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int exp_q[$];

    initial begin
        // Reset state
        idle(3);
        chk_int("reset outputs", int'({spi_clk, sample, shift, busy, done}), 0);
        rst = 1'b1;
        idle(3);

        // D=2 N=3 mode 0
        start_xfer(2, 3, 0, 0);
        idle(20);
        exp_q = '{3, 5, 7, 9, 11, 13}; chk_list("d2n3 toggles", q_tog, exp_q);
        exp_q = '{3, 7, 11};           chk_list("d2n3 sample", q_smp, exp_q);
        exp_q = '{5, 9, 13};           chk_list("d2n3 shift", q_shf, exp_q);
        exp_q = '{15};                 chk_list("d2n3 done", q_done, exp_q);
        exp_q.delete();
        for (int i = 1; i <= 14; i++) exp_q.push_back(i);
        chk_list("d2n3 busy", q_busy, exp_q);

        // D=1 N=2 mode 3, idle high
        cpol = 1'b1;
        idle(3);
        chk_bit("cpol idle level", spi_clk, 1'b1);
        start_xfer(1, 2, 1, 1);
        idle(10);
        exp_q = '{2, 3, 4, 5}; chk_list("d1n2 toggles", q_tog, exp_q);
        exp_q = '{2, 4};       chk_list("d1n2 shift", q_shf, exp_q);
        exp_q = '{3, 5};       chk_list("d1n2 sample", q_smp, exp_q);
        exp_q = '{6};          chk_list("d1n2 done", q_done, exp_q);
        cpol = 1'b0;
        idle(3);

        // clk_divide 0 behaves as 1
        start_xfer(0, 1, 0, 0);
        idle(8);
        exp_q = '{2, 3}; chk_list("div0 toggles", q_tog, exp_q);
        exp_q = '{4};    chk_list("div0 done", q_done, exp_q);

        // Pulse count clamp
        start_xfer(1, MAXLEN + 5, 0, 0);
        idle(40);
        chk_int("clamp sample count", q_smp.size(), MAXLEN);
        chk_int("clamp shift count", q_shf.size(), MAXLEN);
        exp_q = '{2 * MAXLEN + 2}; chk_list("clamp done", q_done, exp_q);

        // Zero-length transfer
        start_xfer(2, 0, 0, 0);
        idle(6);
        exp_q = '{1}; chk_list("n0 done", q_done, exp_q);
        chk_int("n0 busy cycles", q_busy.size(), 0);
        chk_int("n0 toggles", q_tog.size(), 0);

        // Abort in the cycle toggle 3 becomes visible
        start_xfer(2, 3, 0, 0);
        idle(6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle(20);
        exp_q = '{3, 5, 7, 8}; chk_list("abort toggles", q_tog, exp_q);
        exp_q = '{3, 7};       chk_list("abort sample", q_smp, exp_q);
        exp_q.delete();        chk_list("abort done", q_done, exp_q);
        start_xfer(1, 2, 0, 0);
        idle(10);
        exp_q = '{6}; chk_list("after abort done", q_done, exp_q);

        // Asynchronous reset mid-RUN
        start_xfer(2, 3, 0, 0);
        idle(5);
        rst = 1'b0;
        #1;
        chk_int("async reset outputs", int'({spi_clk, sample, shift, busy, done}), 0);
        idle(2);
        rst = 1'b1;
        idle(20);
        exp_q.delete(); chk_list("reset done", q_done, exp_q);
        start_xfer(1, 2, 0, 0);
        idle(10);
        exp_q = '{6}; chk_list("after reset done", q_done, exp_q);

        // start held high: back-to-back D=1 N=1
        clk_divide = 16'd1;
        n_pulses   = 5'd1;
        clear_logs();
        t_ref = cyc;
        start = 1'b1;
        idle(18);
        start = 1'b0;
        idle(10);
        exp_q = '{4, 8, 12, 16, 20}; chk_list("back-to-back done", q_done, exp_q);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 400) != 0);
            start      = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 60) == 0);
            cpol       = 1'($urandom_range(0, 1));
            cpha       = 1'($urandom_range(0, 1));
            clk_divide = ($urandom_range(0, 9) == 0) ? DIVW'($urandom_range(5, 9))
                                                     : DIVW'($urandom_range(0, 3));
            n_pulses   = 5'($urandom_range(0, 21));
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
